// File: rtl/ccff_prog_ctrl_if.sv
// ccff_prog_ctrl_if
// Bitstream word handshake between a configuration source and the chain
// programming controller.
//   cfg_data  : bitstream word (WORD_W bits), consumed LSB first
//   cfg_valid : source has a word on cfg_data
//   cfg_ready : controller will capture cfg_data on this rising edge
// Modports: master = bitstream source, slave = ccff_prog_ctrl.
interface ccff_prog_ctrl_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_prog_ctrl.sv
// ccff_prog_ctrl
// Serialises a word-oriented bitstream into a configuration flip-flop chain.
// After start, words are accepted one at a time over the cfg interface and
// shifted into the chain head LSB first until exactly CHAIN_LEN bits have been
// driven; unused high bits of the last word are dropped.
//
// Optional feature, macro CCFF_PROG_CTRL_READBACK_EN: after programming, the
// chain is recirculated once (tail fed back to head) while a CRC-8 of the
// returning bits is compared with a CRC-8 of the bits that were shifted in.
// Without the macro there is no VERIFY state, error is 0 and ccff_tail is
// ignored.
//
// Ports:
//   prog_clk      : programming clock, rising edge
//   pReset_n      : asynchronous active-low reset
//   start         : one-cycle request to program the chain (ignored when busy)
//   abort         : return to IDLE on the next edge, no done pulse
//   cfg           : bitstream word handshake (slave modport)
//   ccff_head     : serial bit to the chain head
//   ccff_shift_en : chain shifts ccff_head in on this rising edge
//   ccff_tail     : serial bit from the chain tail (readback only)
//   busy/done/error : status
module ccff_prog_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic            prog_clk,
  input  logic            pReset_n,
  input  logic            start,
  input  logic            abort,
  ccff_prog_ctrl_if.slave cfg,
  output logic            ccff_head,
  output logic            ccff_shift_en,
  input  logic            ccff_tail,
  output logic            busy,
  output logic            done,
  output logic            error
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(CHAIN_LEN - 1);
  localparam logic [WW-1:0] LAST_WBIT = WW'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
`ifdef CCFF_PROG_CTRL_READBACK_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_cnt_q;
  logic [WW-1:0]     word_cnt_q;
  logic [WORD_W-1:0] sreg_q;      // bits of the current word not yet driven
  logic              head_q;
  logic              shift_en_q;
  logic              last_bit;
  logic              last_wbit;
  logic              load_take;

  assign last_bit  = (bit_cnt_q == LAST_BIT);
  assign last_wbit = (word_cnt_q == LAST_WBIT);
  assign load_take = (state_q == LOAD) && (state_d == SHIFT);

  // Next state and state-decoded status
  always_comb begin
    state_d       = state_q;
    cfg.cfg_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        cfg.cfg_ready = 1'b1;
        busy          = 1'b1;
        if (abort)              state_d = IDLE;
        else if (cfg.cfg_valid) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        // Chain length wins over word length so the final word's spare
        // high bits are never driven.
        if (abort) state_d = IDLE;
`ifdef CCFF_PROG_CTRL_READBACK_EN
        else if (last_bit)  state_d = VERIFY;
`else
        else if (last_bit)  state_d = DONE;
`endif
        else if (last_wbit) state_d = LOAD;
      end
`ifdef CCFF_PROG_CTRL_READBACK_EN
      VERIFY: begin
        busy = 1'b1;
        if (abort)         state_d = IDLE;
        else if (last_bit) state_d = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, counters and the registered chain strobes
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef CCFF_PROG_CTRL_READBACK_EN
      shift_en_q <= (state_d == SHIFT) || (state_d == VERIFY);
`else
      shift_en_q <= (state_d == SHIFT);
`endif
      case (state_q)
        IDLE: begin
          if (start) bit_cnt_q <= '0;
        end
        LOAD: begin
          if (load_take) begin
            word_cnt_q <= '0;
            head_q     <= cfg.cfg_data[0];
          end
        end
        SHIFT: begin
          if (!abort) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            bit_cnt_q  <= bit_cnt_q + 1'b1;
            if (state_d == SHIFT) head_q <= sreg_q[0];
`ifdef CCFF_PROG_CTRL_READBACK_EN
            // Recirculation pass reuses the bit counter from zero.
            if (state_d == VERIFY) bit_cnt_q <= '0;
`endif
          end
        end
`ifdef CCFF_PROG_CTRL_READBACK_EN
        VERIFY: begin
          if (!abort) bit_cnt_q <= bit_cnt_q + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Word shift register is pure data: it is always reloaded before use.
  always_ff @(posedge prog_clk) begin
    if (load_take)               sreg_q <= cfg.cfg_data >> 1;
    else if (state_q == SHIFT)   sreg_q <= sreg_q >> 1;
  end

  assign ccff_shift_en = shift_en_q;

`ifdef CCFF_PROG_CTRL_READBACK_EN
  logic [7:0] crc_shift_q;
  logic [7:0] crc_tail_q;
  logic [7:0] crc_tail_nxt;
  logic       err_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign crc_tail_nxt = crc8_step(crc_tail_q, ccff_tail);

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      crc_shift_q <= '0;
      crc_tail_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            crc_shift_q <= '0;
            crc_tail_q  <= '0;
            err_q       <= 1'b0;
          end
        end
        SHIFT: begin
          if (!abort) crc_shift_q <= crc8_step(crc_shift_q, head_q);
        end
        VERIFY: begin
          if (!abort) begin
            crc_tail_q <= crc_tail_nxt;
            // Include the final returning bit so error is valid in DONE.
            if (last_bit) err_q <= (crc_tail_nxt != crc_shift_q);
          end
        end
        default: ;
      endcase
    end
  end

  // During recirculation the head must follow the tail within the same
  // cycle; a register in the loop would rotate the chain by one position.
  assign ccff_head = (state_q == VERIFY) ? ccff_tail : head_q;
  assign error     = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign ccff_head   = head_q;
  assign error       = 1'b0;
`endif

endmodule

// File: doc/ccff_prog_ctrl.md
CCFF_PROG_CTRL -- requirements
Module: ccff_prog_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8: number of configuration bits in the attached ccff chain (range 1..4095).
REQ-002 SHALL have parameter WORD_W, default 8: width of the bitstream input word (range 1..32).
REQ-003 SHALL have port prog_clk, input, 1: programming clock; all state updates on its rising edge.
REQ-004 SHALL have port pReset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to program the chain.
REQ-006 SHALL have port abort, input, 1: terminate the operation in progress.
REQ-007 SHALL have port cfg_data, input, WORD_W: bitstream word.
REQ-008 SHALL have port cfg_valid, input, 1: cfg_data valid.
REQ-009 SHALL have port cfg_ready, output, 1: controller accepts cfg_data.
REQ-010 SHALL have port ccff_head, output, 1: serial bit to the chain head.
REQ-011 SHALL have port ccff_shift_en, output, 1: chain shifts ccff_head in on this rising edge.
REQ-012 SHALL have port ccff_tail, input, 1: serial bit from the chain tail.
REQ-013 SHALL have ports busy, done, error, each output, 1: status.

Function
REQ-014 SHALL implement states IDLE, LOAD, SHIFT, VERIFY (readback only), DONE.
REQ-015 IDLE: start=1 -> LOAD; clear bit counter, error and CRC registers; busy=1 from the next cycle.
REQ-016 start received while busy=1 SHALL be ignored.
REQ-017 LOAD: cfg_ready=1; cfg_valid&cfg_ready captures cfg_data into the shift register -> SHIFT; cfg_valid=0 -> stay in LOAD indefinitely.
REQ-018 SHIFT: each cycle SHALL drive one bit with ccff_shift_en=1; bits are taken LSB first; words are consumed in arrival order.
REQ-019 SHIFT SHALL exit after WORD_W bits -> LOAD, or when the total bit count reaches CHAIN_LEN -> VERIFY/DONE, whichever comes first; unused high bits of the final word are discarded.
REQ-020 Words required SHALL be ceil(CHAIN_LEN/WORD_W); exactly CHAIN_LEN shift_en pulses per operation.
REQ-021 ccff_head and ccff_shift_en SHALL be registered outputs; ccff_shift_en=0 outside SHIFT/VERIFY, and ccff_head holds its last value.
REQ-022 DONE SHALL last one cycle with done=1, busy=0, then -> IDLE; error is valid in that cycle.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with ccff_shift_en=0 and cfg_ready=0 from that edge; done is not pulsed and error is unchanged.
REQ-024 abort and start asserted in the same cycle SHALL be resolved abort-first: from IDLE, start is taken; from a busy state, IDLE is entered and start is ignored.
REQ-025 The bit counter SHALL be ceil(log2(CHAIN_LEN+1)) wide and SHALL never wrap.

Reset
REQ-026 pReset_n=0 SHALL asynchronously force IDLE and set cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0; counters and CRC cleared.
REQ-027 Reset asserted mid-SHIFT SHALL drop ccff_shift_en immediately, leaving the chain contents undefined; reprogramming requires a new start.

Configuration
REQ-028 The macro CCFF_PROG_CTRL_READBACK_EN SHALL compile in readback verification.
REQ-029 With the macro: a serial CRC-8 (poly 0x07, init 0x00, fb=crc[7]^bit, crc={crc[6:0],0}^(fb?0x07:0)) SHALL accumulate over every shifted bit.
REQ-030 With the macro, VERIFY SHALL run CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail (content-preserving recirculation), accumulating a second CRC over ccff_tail.
REQ-031 With the macro, a mismatch between the two CRCs SHALL set error=1 in DONE; error is sticky until the next accepted start.
REQ-032 Without the macro: no VERIFY state, no CRC logic; SHIFT exits directly to DONE, error is tied 0 and ccff_tail is unused.

Verification
REQ-033 CHAIN_LEN=8, WORD_W=8, start, word 0xA5 -> ccff_head sequence 1,0,1,0,0,1,0,1 over 8 shift_en cycles; done one cycle later (no readback).
REQ-034 CHAIN_LEN=10, WORD_W=8, words 0xFF then 0x02 -> 10 shift_en pulses, last two bits 0,1; exactly two cfg handshakes.
REQ-035 cfg_valid withheld 20 cycles in LOAD -> ccff_shift_en=0 and busy=1 throughout; resumes cleanly.
REQ-036 abort on the 3rd shift cycle -> ccff_shift_en=0 next cycle, state IDLE, no done pulse; a new start then programs the chain fully.
REQ-037 Readback on, behavioural 8-bit chain model, 0x3C -> error=0; the model corrupts one bit -> error=1 in DONE.
REQ-038 pReset_n pulsed low mid-SHIFT -> all outputs 0 asynchronously; start then completes normally.
